// File: rtl/key_direction_ctrl_if.sv
// Key inputs and debounced control outputs of the push-button front end.
// The design side uses the slave modport; whatever drives the keys uses master.
interface key_direction_ctrl_if;
    logic key_dir;
    logic key_run;
    logic direction;
    logic run;
    logic dir_pulse;
    logic run_pulse;

    modport master (
        output key_dir,
        output key_run,
        input  direction,
        input  run,
        input  dir_pulse,
        input  run_pulse
    );

    modport slave (
        input  key_dir,
        input  key_run,
        output direction,
        output run,
        output dir_pulse,
        output run_pulse
    );
endinterface

// File: rtl/key_direction_ctrl.sv
// Two independent key channels: synchronise, debounce press and release, and
// toggle a level output with a one-cycle pulse on every accepted press.
module key_direction_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    key_direction_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 is the direction key, channel 1 the run/pause key.
    logic [1:0] raw;
    logic [1:0] ff1;
    logic [1:0] ff2;
    logic [1:0] level;
    logic [1:0] pulse;

    assign raw = {bus.key_run, bus.key_dir};

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1 <= 2'b00;
            ff2 <= 2'b00;
        end else begin
            ff1 <= raw;
            ff2 <= ff1;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             s;
        logic [1:0]       state_q;
        logic [1:0]       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             pulse_q;
        logic             pulse_d;

        assign s = ff2[ch];

        // The counter is cleared on entry to each check state and only
        // advances below its terminal value, so it can never wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_CHK;
                        cnt_d   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        pulse_d = 1'b1;
                        level_d = ~level_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_CHK;
                        cnt_d   = '0;
                    end
                end
                RELEASE_CHK: begin
                    if (s) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign level[ch] = level_q;
        assign pulse[ch] = pulse_q;
    end

    assign bus.direction = level[0];
    assign bus.run       = level[1];
    assign bus.dir_pulse = pulse[0];
    assign bus.run_pulse = pulse[1];

endmodule

// File: doc/key_direction_ctrl.md
# key_direction_ctrl

Push-button front end for the two-digit up/down display counter. Synchronises and debounces two raw key inputs and turns each clean press into a toggle of a level output. `direction` drives the counter's `direction` input; `run` drives its count-enable. Also emits one-cycle press pulses for any other consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: stable-input cycles required to accept a press or release (20 ms at the 1 MHz board clock); legal range 2..2^CNT_W.
- `CNT_W`, default 15: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- `clk` input 1: the single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `key_dir` input 1: raw direction key, asynchronous, high = pressed, bouncy.
- `key_run` input 1: raw run/pause key, asynchronous, high = pressed, bouncy.
- `direction` output 1: 1 = count up, 0 = count down; toggles on each accepted `key_dir` press.
- `run` output 1: 1 = counter enabled, 0 = paused; toggles on each accepted `key_run` press.
- `dir_pulse` output 1: high for exactly one cycle per accepted `key_dir` press.
- `run_pulse` output 1: high for exactly one cycle per accepted `key_run` press.

## Operation
- There are two identical, fully independent channels: `key_dir` → `direction`/`dir_pulse`, and `key_run` → `run`/`run_pulse`.
- Synchroniser, per channel: two flops, ff1 then ff2. `s` = ff2. The FSM reads only `s`.
- FSM, per channel, with one debounce counter `cnt` (CNT_W bits):
  - IDLE: if `s`=1, go to PRESS_CHK with `cnt`←0.
  - PRESS_CHK:
    - `s`=0: go to IDLE (bounce rejected; no pulse).
    - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to PRESSED, assert pulse, invert level output.
    - Otherwise `cnt`←`cnt`+1.
  - PRESSED: if `s`=0, go to RELEASE_CHK with `cnt`←0. Holding the key produces no further pulses (no auto-repeat).
  - RELEASE_CHK:
    - `s`=1: go to PRESSED (release bounce rejected; no pulse, no toggle).
    - `s`=0 and `cnt`==DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise `cnt`←`cnt`+1.
- `cnt` never wraps. It is only incremented below DEBOUNCE_CYCLES-1 and is cleared on every state entry that uses it.
- Pulse is registered. It is high only in the cycle following the PRESS_CHK→PRESSED transition.
- Level output changes only at PRESS_CHK→PRESSED. Its value is held in every other state.

## Timing
- Reset, at any posedge with `rst`=1:
  - ff1=ff2=0, both FSMs IDLE, `cnt`=0.
  - `direction`=1, `run`=1, `dir_pulse`=0, `run_pulse`=0.
- Reset asserted mid-operation has priority over everything. It aborts any in-progress debounce and restores the values above.
- A key still held when `rst` drops is treated as a new press and is accepted after the normal latency.
- Press latency: raw high first sampled at edge k and stable thereafter → transition, toggle and pulse at edge k+DEBOUNCE_CYCLES+2. The pulse is visible in cycle k+N+2..k+N+3.
- Minimum accepted press: raw high stable for DEBOUNCE_CYCLES+1 consecutive sampling edges. Any shorter high is rejected.
- Minimum press-to-press spacing: ≈2·DEBOUNCE_CYCLES+4 cycles, because release must also debounce before IDLE.
- Simultaneous presses on both keys are independent. Both pulses may assert in the same cycle and both levels toggle.
- The downstream counter samples `direction`/`run` every cycle. A toggle takes effect at its next count tick; no handshake.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset: hold `rst` 3 cycles with both keys at 0 → `direction`=1, `run`=1, both pulses 0. Values are stable for 20 further cycles.
- Clean press: `key_dir` 0→1 before edge 10 and held 30 cycles → `dir_pulse`=1 only in the cycle after edge 16; `direction` 1→0 at edge 16; no further pulse while held. Release, wait 10 cycles, press again → `direction` back to 1.
- Bounce rejection: `key_dir` high 3 cycles, low 1, high 2, low → no pulse; `direction` stays 1. Then press bouncing for 5 cycles followed by a stable high → exactly one pulse, timed N+2 edges after the last rising edge.
- Release bounce: hold `key_run` until `run`=0, then toggle it low/high with 2-cycle periods for 12 cycles, then low → no extra `run_pulse`; `run` stays 0.
- Simultaneous: both keys rise at edge 40 → both pulses high in the same cycle after edge 46; `direction` and `run` both invert.
- Reset mid-debounce: `key_dir` high from edge 60, `rst`=1 at edge 63 for 1 cycle, key still held → no pulse before reset; exactly one pulse at edge 64+N+2=70.
